regfile_mp: RTL and testbench

- Parametrised multi-port integer register file with an integrated scoreboard (per-register busy bits). Successor to the 2R1W file.
- Sits between decode/issue and writeback. Provides NRD combinational read ports with same-cycle write bypass.
- Provides NWR prioritised write ports and busy tracking so issue logic can stall on pending writes.
- Register 0 is hardwired to zero and is never busy.

---
 rtl/regfile_mp.sv | 113 +++++++++++
 tb/tb_regfile_mp.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with per-register busy scoreboard.
// NRD combinational read ports with same-cycle write bypass, NWR prioritised
// write ports (higher index wins), x0 hardwired to zero and never busy.
// Optional macro DIFF_EN adds regs_o, the post-write view of every register.
module regfile_mp #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned NREGS = 32,
   parameter int unsigned NRD   = 4,
   parameter int unsigned NWR   = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NRD*$clog2(NREGS)-1:0]    rs_addr,
   output logic [NRD*XLEN-1:0]             rs_data,
   output logic [NRD-1:0]                  rs_busy,
   input  logic [NWR-1:0]                  we,
   input  logic [NWR*$clog2(NREGS)-1:0]    waddr,
   input  logic [NWR*XLEN-1:0]             wdata,
   input  logic                            alloc_en,
   input  logic [$clog2(NREGS)-1:0]        alloc_addr,
   input  logic                            flush,
`ifdef DIFF_EN
   output logic [NREGS*XLEN-1:0]           regs_o,
`endif
   output logic [$clog2(NREGS+1)-1:0]      busy_cnt
);

   localparam int unsigned AW = $clog2(NREGS);
   localparam int unsigned CW = $clog2(NREGS+1);

   logic [NREGS-1:0][XLEN-1:0] rf_q;
   logic [NREGS-1:0][XLEN-1:0] rf_d;
   logic [NREGS-1:0][XLEN-1:0] wr_val;
   logic [NREGS-1:0]           wr_hit;
   logic [NREGS-1:0]           busy_q;
   logic [NREGS-1:0]           busy_d;
   logic [CW-1:0]              cnt_q;
   logic [CW-1:0]              cnt_d;

   // Resolve the winning write per register; later ports override earlier ones.
   always_comb begin
      wr_hit = '0;
      wr_val = '0;
      for (int r = 1; r < int'(NREGS); r++) begin
         for (int j = 0; j < int'(NWR); j++) begin
            if (we[j] && (waddr[j*AW +: AW] == AW'(r))) begin
               wr_hit[r] = 1'b1;
               wr_val[r] = wdata[j*XLEN +: XLEN];
            end
         end
      end
   end

   // Post-write register view; x0 never hits so it stays at its reset zero.
   always_comb begin
      rf_d = rf_q;
      for (int r = 1; r < int'(NREGS); r++) begin
         if (wr_hit[r]) rf_d[r] = wr_val[r];
      end
      rf_d[0] = '0;
   end

   // Busy next-state: flush, then alloc, then write-clear, else hold.
   always_comb begin
      busy_d = busy_q;
      for (int r = 1; r < int'(NREGS); r++) begin
         if (flush)                                         busy_d[r] = 1'b0;
         else if (alloc_en && (alloc_addr == AW'(r)))       busy_d[r] = 1'b1;
         else if (wr_hit[r])                                busy_d[r] = 1'b0;
      end
      busy_d[0] = 1'b0;
   end

   // Popcount of the next busy vector so busy_cnt tracks the registered bits.
   always_comb begin
      cnt_d = '0;
      for (int r = 0; r < int'(NREGS); r++) begin
         cnt_d = cnt_d + CW'(busy_d[r]);
      end
   end

   // Read ports: bypassed data and same-cycle busy view, forced to zero in reset.
   always_comb begin
      rs_data = '0;
      rs_busy = '0;
      if (rst_n) begin
         for (int i = 0; i < int'(NRD); i++) begin
            rs_data[i*XLEN +: XLEN] = rf_d[rs_addr[i*AW +: AW]];
            rs_busy[i]              = busy_d[rs_addr[i*AW +: AW]];
         end
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_q   <= '0;
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         rf_q   <= rf_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_cnt = cnt_q;

`ifdef DIFF_EN
   assign regs_o = rf_d;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with default parameters (64b, 32 regs, 4R, 2W).
module tb_regfile_mp;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned NREGS = 32;
   localparam int unsigned NRD   = 4;
   localparam int unsigned NWR   = 2;
   localparam int unsigned AW    = 5;
   localparam int unsigned CW    = 6;

   logic                 clk;
   logic                 clk_en;
   logic                 rst_n;
   logic [NRD*AW-1:0]    rs_addr;
   logic [NRD*XLEN-1:0]  rs_data;
   logic [NRD-1:0]       rs_busy;
   logic [NWR-1:0]       we;
   logic [NWR*AW-1:0]    waddr;
   logic [NWR*XLEN-1:0]  wdata;
   logic                 alloc_en;
   logic [AW-1:0]        alloc_addr;
   logic                 flush;
   logic [CW-1:0]        busy_cnt;
`ifdef DIFF_EN
   logic [NREGS*XLEN-1:0] regs_o;
`endif

   int total = 0;
   int bad   = 0;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
      .we(we), .waddr(waddr), .wdata(wdata),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
`ifdef DIFF_EN
      .regs_o(regs_o),
`endif
      .busy_cnt(busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = clk_en ? ~clk : clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rd(input int i);
      return rs_data[i*XLEN +: XLEN];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = '0; waddr = '0; wdata = '0;
      alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
   endtask

   task automatic set_rd(input int i, input logic [AW-1:0] a);
      rs_addr[i*AW +: AW] = a;
   endtask

   task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [63:0] d);
      we[j] = 1'b1;
      waddr[j*AW +: AW] = a;
      wdata[j*XLEN +: XLEN] = d;
   endtask

   task automatic alloc(input logic [AW-1:0] a);
      alloc_en = 1'b1;
      alloc_addr = a;
   endtask

   initial begin
      clk_en = 1'b0;
      rst_n  = 1'b1;
      rs_addr = '0;
      idle();
      set_rd(0, 5'd1); set_rd(1, 5'd2); set_rd(2, 5'd3); set_rd(3, 5'd31);

      // Asynchronous reset with the clock stopped.
      #3 rst_n = 1'b0;
      #1;
      for (int i = 0; i < int'(NRD); i++) chk($sformatf("rst_data%0d", i), rd(i), 64'h0);
      chk("rst_busy", 64'(rs_busy), 64'h0);
      chk("rst_cnt", 64'(busy_cnt), 64'h0);
      #2 rst_n = 1'b1;
      clk_en = 1'b1;
      tick();

      // Write x5 then read it on every port.
      set_wr(0, 5'd5, 64'h1234);
      tick();
      idle();
      for (int i = 0; i < int'(NRD); i++) set_rd(i, 5'd5);
      #1;
      for (int i = 0; i < int'(NRD); i++) chk($sformatf("x5_port%0d", i), rd(i), 64'h1234);

      // Port priority and same-cycle bypass on x7.
      set_rd(2, 5'd7);
      set_wr(0, 5'd7, 64'hAAAA);
      set_wr(1, 5'd7, 64'hBBBB);
      #1;
      chk("prio_bypass", rd(2), 64'hBBBB);
`ifdef DIFF_EN
      chk("diff_x7", regs_o[7*XLEN +: XLEN], 64'hBBBB);
`endif
      tick();
      idle();
      #1;
      chk("prio_stored", rd(2), 64'hBBBB);

      // x0 protection.
      set_rd(0, 5'd0);
      set_wr(0, 5'd0, 64'hFFFF);
      set_wr(1, 5'd0, 64'hFFFF);
      alloc(5'd0);
      #1;
      chk("x0_data", rd(0), 64'h0);
      chk("x0_busy", 64'(rs_busy[0]), 64'h0);
      tick();
      idle();
      #1;
      chk("x0_data_after", rd(0), 64'h0);
      chk("x0_cnt", 64'(busy_cnt), 64'h0);

      // Scoreboard lifecycle on x3.
      set_rd(1, 5'd3);
      alloc(5'd3);
      #1;
      chk("x3_alloc_busy", 64'(rs_busy[1]), 64'h1);
      tick();
      idle();
      #1;
      chk("x3_cnt1", 64'(busy_cnt), 64'h1);
      chk("x3_busy_held", 64'(rs_busy[1]), 64'h1);
      tick();
      set_wr(0, 5'd3, 64'h42);
      #1;
      chk("x3_wr_busy", 64'(rs_busy[1]), 64'h0);
      chk("x3_wr_data", rd(1), 64'h42);
      tick();
      idle();
      #1;
      chk("x3_cnt0", 64'(busy_cnt), 64'h0);

      // Alloc/write collision on busy x9.
      set_rd(3, 5'd9);
      alloc(5'd9);
      tick();
      idle();
      #1;
      chk("x9_cnt", 64'(busy_cnt), 64'h1);
      set_wr(0, 5'd9, 64'h55);
      alloc(5'd9);
      #1;
      chk("coll_busy_c", 64'(rs_busy[3]), 64'h1);
      chk("coll_data_c", rd(3), 64'h55);
      tick();
      idle();
      #1;
      chk("coll_busy", 64'(rs_busy[3]), 64'h1);
      chk("coll_data", rd(3), 64'h55);
      chk("coll_cnt", 64'(busy_cnt), 64'h1);

      // Flush with a same-cycle alloc.
      alloc(5'd1); tick();
      alloc(5'd2); tick();
      alloc(5'd4); tick();
      idle();
      #1;
      chk("pre_flush_cnt", 64'(busy_cnt), 64'h4);
      set_rd(0, 5'd6);
      set_rd(1, 5'd1);
      flush = 1'b1;
      alloc(5'd6);
      #1;
      chk("flush_x6_c", 64'(rs_busy[0]), 64'h0);
      chk("flush_x1_c", 64'(rs_busy[1]), 64'h0);
      tick();
      idle();
      set_rd(0, 5'd5); set_rd(1, 5'd7); set_rd(2, 5'd9); set_rd(3, 5'd6);
      #1;
      chk("flush_cnt", 64'(busy_cnt), 64'h0);
      chk("flush_busy", 64'(rs_busy), 64'h0);
      chk("flush_x5", rd(0), 64'h1234);
      chk("flush_x7", rd(1), 64'hBBBB);
      chk("flush_x9", rd(2), 64'h55);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
